// File: rtl/ft64_pti_pkg.sv
// ft64_pti_pkg: register map, CTRL/STATUS bit positions and port FSM states
package ft64_pti_pkg;
  localparam logic [2:0] A_DATA = 3'd0, A_CTRL = 3'd1, A_STAT = 3'd2, A_RXL = 3'd3;
  localparam logic [2:0] A_RXH = 3'd4, A_TXL = 3'd5, A_TXH = 3'd6;
  localparam int C_LB = 0, C_RXEN = 1, C_TXEN = 2, C_SIWU = 3, C_RXIE = 4, C_TXIE = 5, C_SRST = 7;
  localparam int S_RXE = 0, S_RXF = 1, S_TXE = 2, S_TXF = 3, S_RXWM = 4, S_TXWM = 5, S_UNF = 6, S_IRQ = 7;
  typedef enum logic [2:0] {IDLE, RD_OE, RD, WR, TA} pstate_t;
endpackage

// File: rtl/ft64_pti_fifo.sv
// ft64_pti_fifo: first-word-fall-through byte FIFO, pop-before-push when full
module ft64_pti_fifo #(
  parameter int AW = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [7:0] mem [2**AW];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign count = wp - rp;
  assign empty = wp == rp;
  assign full = count[AW];
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp[AW-1:0]];
  // storage array, contents are don't-care after reset
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
  // read/write pointers; an empty pop is ignored so push wins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, do_push};
      rp <= rp + {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/ft64_pti3.sv
// ft64_pti3: Wishbone slave bridging to an FT245-style synchronous FIFO device
module ft64_pti3 import ft64_pti_pkg::*; #(
  parameter int AW = 9,
  parameter int BURST = 64,
  parameter int RXWM = 256,
  parameter int TXWM = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [3:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       irq_o,
  input  logic       rxf_ni,
  input  logic       txe_ni,
  input  logic [7:0] pd_i,
  output logic [7:0] pd_o,
  output logic       pd_oe_o,
  output logic       rd_no,
  output logic       wr_no,
  output logic       oe_no,
  output logic       siwu_no
);
  logic q, done, stall, acc, wr, rd, srst, lb_mv;
  logic lb, rx_en, tx_en, rxie, txie, siwu_p, unf, last_wr;
  logic rx_push, rx_pop, tx_push, tx_pop, rx_full, rx_empty, tx_full, tx_empty;
  logic rx_ge, tx_le, tx_work, go_rd, siwu_take;
  logic [2:0] a;
  logic [7:0] rdat, rx_hi, tx_hi, rx_dout, tx_dout;
  logic [15:0] rc, tc, bc;
  logic [AW:0] rx_cnt, tx_cnt;
  logic unused_adr;
  pstate_t st;
  assign unused_adr = wb_adr_i[3];
  ft64_pti_fifo #(.AW(AW)) u_rx (.clk(clk_i), .rst(rst_i), .flush(srst), .push(rx_push), .din(pd_i),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_cnt));
  ft64_pti_fifo #(.AW(AW)) u_tx (.clk(clk_i), .rst(rst_i), .flush(srst), .push(tx_push),
    .din(lb ? rx_dout : wb_dat_i), .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty),
    .count(tx_cnt));
  // strobes and drive enable come only from registered state and FIFO flags
  assign rd_no = ~(st == RD & ~rx_full);
  assign oe_no = ~(st == RD_OE | st == RD);
  assign wr_no = ~(st == WR & ~tx_empty);
  assign pd_oe_o = st == WR;
  assign pd_o = pd_oe_o ? tx_dout : 8'h00;
  // bus qualification, FIFO steering, arbitration and read mux
  always_comb begin
    a = wb_adr_i[2:0];
    q = cs_i & wb_cyc_i & wb_stb_i;
    stall = wb_we_i & (a == A_DATA) & ~lb & tx_full;
    acc = q & ~done & ~wb_ack_o & ~stall;
    wr = acc & wb_we_i;
    rd = acc & ~wb_we_i;
    srst = wr & (a == A_CTRL) & wb_dat_i[C_SRST];
    lb_mv = lb & ~rx_empty & ~tx_full;
    rx_push = (st == RD) & ~rx_full & ~rxf_ni;
    tx_pop = (st == WR) & ~tx_empty & ~txe_ni;
    rx_pop = lb_mv | (rd & (a == A_DATA) & ~lb & ~rx_empty);
    tx_push = lb_mv | (wr & (a == A_DATA) & ~lb);
    rc = 16'(rx_cnt);
    tc = 16'(tx_cnt);
    rx_ge = rxie & (32'(rx_cnt) >= RXWM);
    tx_le = txie & (32'(tx_cnt) <= TXWM);
    tx_work = tx_en & ~txe_ni & ~tx_empty;
    go_rd = rx_en & ~rxf_ni & ~rx_full & (last_wr | ~tx_work);
    siwu_take = (st == IDLE) & ~go_rd & ~tx_work & siwu_p;
    rdat = 8'h00;
    case (a)
      A_DATA: rdat = (lb | rx_empty) ? 8'h00 : rx_dout;
      A_CTRL: rdat = {2'b00, txie, rxie, siwu_p, tx_en, rx_en, lb};
      A_STAT: rdat = {irq_o, unf, tx_le, rx_ge, tx_full, tx_empty, rx_full, rx_empty};
      A_RXL:  rdat = rc[7:0];
      A_RXH:  rdat = rx_hi;
      A_TXL:  rdat = tc[7:0];
      A_TXH:  rdat = tx_hi;
      default: rdat = 8'h00;
    endcase
  end
  // register file, one-shot ack that re-arms once the strobe is seen low
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      done <= 1'b0;
      wb_dat_o <= 8'h00;
      irq_o <= 1'b0;
      {txie, rxie, tx_en, rx_en, lb} <= 5'b00110;
      siwu_p <= 1'b0;
      unf <= 1'b0;
      rx_hi <= 8'h00;
      tx_hi <= 8'h00;
    end else begin
      wb_ack_o <= acc;
      done <= q & (done | wb_ack_o);
      irq_o <= rx_ge | tx_le;
      if (acc) wb_dat_o <= rdat;
      if (siwu_take) siwu_p <= 1'b0;
      if (rd & (a == A_DATA) & ~lb & rx_empty) unf <= 1'b1;
      if (rd & (a == A_RXL)) rx_hi <= rc[15:8];
      if (rd & (a == A_TXL)) tx_hi <= tc[15:8];
      if (wr & (a == A_CTRL)) begin
        {txie, rxie} <= {wb_dat_i[C_TXIE], wb_dat_i[C_RXIE]};
        {tx_en, rx_en, lb} <= {wb_dat_i[C_TXEN], wb_dat_i[C_RXEN], wb_dat_i[C_LB]};
        if (wb_dat_i[C_SIWU]) siwu_p <= 1'b1;
      end
      if ((wr & (a == A_STAT) & wb_dat_i[S_UNF]) | srst) unf <= 1'b0;
    end
  // port FSM; reads win after a write burst or when no write work is pending
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      st <= IDLE;
      bc <= '0;
      last_wr <= 1'b1;
      siwu_no <= 1'b1;
    end else begin
      siwu_no <= ~siwu_take;
      if (srst) begin
        st <= IDLE;
        bc <= '0;
      end else case (st)
        IDLE: begin
          bc <= '0;
          if (go_rd) begin
            st <= RD_OE;
            last_wr <= 1'b0;
          end else if (tx_work) begin
            st <= WR;
            last_wr <= 1'b1;
          end
        end
        RD_OE: st <= RD;
        RD: begin
          bc <= bc + 16'(rx_push);
          if (rxf_ni | rx_full | ~rx_en | (rx_push & (bc == 16'(BURST - 1)))) st <= TA;
        end
        WR: begin
          bc <= bc + 16'(tx_pop);
          if (txe_ni | tx_empty | ~tx_en | (tx_pop & (bc == 16'(BURST - 1)))) st <= TA;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ft64_pti3.sv
// tb_ft64_pti3: randomized scenarios against a queue-based device/FIFO model
module tb_ft64_pti3;
  localparam int AW = 7, DEPTH = 128, BURST = 64, RXWM = 4, TXWM = 8;
  localparam logic [3:0] DATA = 0, CTRL = 1, STAT = 2, RXL = 3, TXL = 5;
  logic clk_i = 0, rst_i = 1, cs_i = 0, wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
  logic [3:0] wb_adr_i = 0;
  logic [7:0] wb_dat_i = 0, pd_i = 0;
  logic rxf_ni = 1, txe_ni = 1;
  logic [7:0] wb_dat_o, pd_o;
  logic wb_ack_o, irq_o, pd_oe_o, rd_no, wr_no, oe_no, siwu_no;
  int n_chk = 0, n_fail = 0;
  byte unsigned host[$], dev_rx[$], exp_q[$];
  int runs[$];
  int run = 0, tx_limit = 0, cyc = 0, wr_low = 0, oe_bad = 0, irq_rise = -1, last_push = 0;
  logic rx_go = 0;
  logic [7:0] r;

  ft64_pti3 #(.AW(AW), .BURST(BURST), .RXWM(RXWM), .TXWM(TXWM)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .irq_o(irq_o), .rxf_ni(rxf_ni), .txe_ni(txe_ni), .pd_i(pd_i),
    .pd_o(pd_o), .pd_oe_o(pd_oe_o), .rd_no(rd_no), .wr_no(wr_no), .oe_no(oe_no), .siwu_no(siwu_no));

  always #8 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // device model: offers host bytes, sinks written bytes, logs burst runs
  initial begin
    forever begin
      logic cap, wcap;
      logic [7:0] wd;
      @(negedge clk_i);
      cap = !rd_no && !rxf_ni;
      wcap = !wr_no && !txe_ni;
      wd = pd_o;
      if (!wr_no) wr_low++;
      if (wcap && !pd_oe_o) oe_bad++;
      @(posedge clk_i);
      #1;
      cyc++;
      if (cap) begin
        void'(host.pop_front());
        last_push = cyc;
        if (run < 0) begin runs.push_back(run); run = 0; end
        run++;
      end else if (wcap) begin
        dev_rx.push_back(wd);
        tx_limit--;
        if (run > 0) begin runs.push_back(run); run = 0; end
        run--;
      end else if (run != 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (irq_o && irq_rise < 0) irq_rise = cyc;
      rxf_ni = !(rx_go && host.size() > 0);
      pd_i = host.size() > 0 ? host[0] : 8'h00;
      txe_ni = !(tx_limit > 0);
    end
  end

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [7:0] d, output logic [7:0] rv);
    int t = 0;
    @(negedge clk_i);
    {cs_i, wb_cyc_i, wb_stb_i, wb_we_i} = {3'b111, we};
    wb_adr_i = adr;
    wb_dat_i = d;
    do begin @(posedge clk_i); #2; t++; end while (!wb_ack_o && t < 1000);
    rv = wb_dat_o;
    n_chk++;
    if (!wb_ack_o) begin n_fail++; $display("FAIL ack_timeout adr=%0d ack=%b want 1", adr, wb_ack_o); end
    {cs_i, wb_cyc_i, wb_stb_i, wb_we_i} = 4'b0000;
    @(posedge clk_i);
    #2;
  endtask

  task automatic wb_w(input logic [3:0] adr, input logic [7:0] d);
    logic [7:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic wb_r(input logic [3:0] adr, output logic [7:0] rv);
    wb_xfer(1'b0, adr, 8'h00, rv);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic test_reset;
    idle(3);
    n_chk++;
    if ({wb_dat_o, wb_ack_o, irq_o, pd_o, pd_oe_o, rd_no, wr_no, oe_no, siwu_no} !== {8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'hf}) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want %h", {wb_dat_o, wb_ack_o, irq_o, pd_o, pd_oe_o, rd_no, wr_no, oe_no, siwu_no}, {8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'hf});
    end
    rst_i = 0;
    idle(2);
    wb_r(CTRL, r);
    n_chk++;
    if (r !== 8'h06) begin n_fail++; $display("FAIL reset_ctrl got %h want 06", r); end
    wb_r(STAT, r);
    n_chk++;
    if (r !== 8'h05) begin n_fail++; $display("FAIL reset_status got %h want 05", r); end
    wb_r(RXL, r);
    n_chk++;
    if (r !== 8'h00) begin n_fail++; $display("FAIL reset_rxcnt got %h want 00", r); end
  endtask

  task automatic test_single_write;
    dev_rx.delete();
    wr_low = 0;
    oe_bad = 0;
    tx_limit = 100;
    idle(2);
    wb_w(DATA, 8'hA5);
    idle(10);
    n_chk++;
    if (dev_rx.size() != 1 || dev_rx[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_write_byte got n=%0d b0=%h want n=1 b0=a5", dev_rx.size(), dev_rx.size() ? dev_rx[0] : 8'h00);
    end
    n_chk++;
    if (wr_low != 1) begin n_fail++; $display("FAIL single_write_wr_low got %0d want 1", wr_low); end
    n_chk++;
    if (oe_bad != 0) begin n_fail++; $display("FAIL single_write_oe got %0d undriven edges want 0", oe_bad); end
    tx_limit = 0;
    wb_r(TXL, r);
    n_chk++;
    if (r !== 8'h00) begin n_fail++; $display("FAIL single_write_txcnt got %h want 00", r); end
  endtask

  task automatic test_burst_fair;
    byte unsigned rx_exp[$];
    dev_rx.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'($urandom));
      wb_w(DATA, exp_q[i]);
    end
    for (int i = 0; i < 100; i++) begin
      rx_exp.push_back(8'($urandom));
      host.push_back(rx_exp[i]);
    end
    runs.delete();
    @(negedge clk_i);
    rx_go = 1;
    tx_limit = 1000;
    idle(300);
    n_chk++;
    if (runs.size() != 3 || runs[0] != BURST || runs[1] != -10 || runs[2] != 100 - BURST) begin
      n_fail++;
      $display("FAIL burst_runs got n=%0d %0d %0d %0d want 3 runs 64 -10 36", runs.size(),
        runs.size() > 0 ? runs[0] : 0, runs.size() > 1 ? runs[1] : 0, runs.size() > 2 ? runs[2] : 0);
    end
    n_chk++;
    if (dev_rx != exp_q) begin n_fail++; $display("FAIL burst_tx_data got n=%0d want n=10 in order", dev_rx.size()); end
    rx_go = 0;
    tx_limit = 0;
    wb_r(RXL, r);
    n_chk++;
    if (r !== 8'd100) begin n_fail++; $display("FAIL burst_rxcnt got %0d want 100", r); end
    for (int i = 0; i < 100; i++) begin
      wb_r(DATA, r);
      n_chk++;
      if (r !== rx_exp[i]) begin n_fail++; $display("FAIL burst_rx_data[%0d] got %h want %h", i, r, rx_exp[i]); end
    end
  endtask

  task automatic test_tx_full;
    int early = 0;
    logic [7:0] x = 8'($urandom);
    exp_q.delete();
    dev_rx.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'($urandom));
      wb_w(DATA, exp_q[i]);
    end
    wb_r(TXL, r);
    n_chk++;
    if (r !== 8'(DEPTH)) begin n_fail++; $display("FAIL full_txcnt got %h want %h", r, 8'(DEPTH)); end
    wb_r(STAT, r);
    n_chk++;
    if (r !== 8'h09) begin n_fail++; $display("FAIL full_status got %h want 09", r); end
    fork
      wb_w(DATA, x);
      begin
        repeat (20) begin @(negedge clk_i); if (wb_ack_o) early++; end
        tx_limit = 1;
      end
    join
    n_chk++;
    if (early != 0) begin n_fail++; $display("FAIL full_ack_stall got %0d early acks want 0", early); end
    n_chk++;
    if (dev_rx.size() != 1 || dev_rx[0] !== exp_q[0]) begin n_fail++; $display("FAIL full_drain_one got n=%0d want 1 byte %h", dev_rx.size(), exp_q[0]); end
    wb_r(TXL, r);
    n_chk++;
    if (r !== 8'(DEPTH)) begin n_fail++; $display("FAIL full_txcnt_after got %h want %h", r, 8'(DEPTH)); end
    void'(exp_q.pop_front());
    exp_q.push_back(x);
    dev_rx.delete();
    tx_limit = 1000;
    idle(400);
    tx_limit = 0;
    n_chk++;
    if (dev_rx != exp_q) begin n_fail++; $display("FAIL full_drain_data got n=%0d want n=%0d in order", dev_rx.size(), exp_q.size()); end
  endtask

  task automatic test_underflow;
    wb_r(DATA, r);
    n_chk++;
    if (r !== 8'h00) begin n_fail++; $display("FAIL unf_data got %h want 00", r); end
    wb_r(STAT, r);
    n_chk++;
    if (r !== 8'h45) begin n_fail++; $display("FAIL unf_status_set got %h want 45", r); end
    wb_w(STAT, 8'h40);
    wb_r(STAT, r);
    n_chk++;
    if (r !== 8'h05) begin n_fail++; $display("FAIL unf_status_clr got %h want 05", r); end
  endtask

  task automatic test_irq;
    byte unsigned b[$];
    wb_w(CTRL, 8'h16);
    idle(2);
    irq_rise = -1;
    for (int i = 0; i < RXWM; i++) begin b.push_back(8'($urandom)); host.push_back(b[i]); end
    @(negedge clk_i);
    rx_go = 1;
    idle(20);
    rx_go = 0;
    n_chk++;
    if (irq_rise != last_push + 1) begin n_fail++; $display("FAIL irq_rise got cycle %0d want %0d", irq_rise, last_push + 1); end
    wb_r(STAT, r);
    n_chk++;
    if (r !== 8'h94) begin n_fail++; $display("FAIL irq_status got %h want 94", r); end
    wb_r(DATA, r);
    n_chk++;
    if (r !== b[0]) begin n_fail++; $display("FAIL irq_pop_data got %h want %h", r, b[0]); end
    idle(3);
    n_chk++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_fall got %b want 0", irq_o); end
    for (int i = 1; i < RXWM; i++) wb_r(DATA, r);
    wb_w(CTRL, 8'h26);
    idle(3);
    n_chk++;
    if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_tx_wm got %b want 1", irq_o); end
    wb_w(CTRL, 8'h06);
    idle(3);
    n_chk++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b want 0", irq_o); end
  endtask

  task automatic test_loopback;
    exp_q.delete();
    dev_rx.delete();
    wb_w(CTRL, 8'h07);
    for (int i = 0; i < 5; i++) begin exp_q.push_back(8'($urandom)); host.push_back(exp_q[i]); end
    @(negedge clk_i);
    rx_go = 1;
    idle(40);
    rx_go = 0;
    wb_w(DATA, 8'h33);
    wb_r(DATA, r);
    n_chk++;
    if (r !== 8'h00) begin n_fail++; $display("FAIL lb_data_read got %h want 00", r); end
    wb_r(TXL, r);
    n_chk++;
    if (r !== 8'd5) begin n_fail++; $display("FAIL lb_txcnt got %0d want 5", r); end
    wb_r(RXL, r);
    n_chk++;
    if (r !== 8'd0) begin n_fail++; $display("FAIL lb_rxcnt got %0d want 0", r); end
    wb_w(CTRL, 8'h06);
    tx_limit = 100;
    idle(40);
    tx_limit = 0;
    n_chk++;
    if (dev_rx != exp_q) begin n_fail++; $display("FAIL lb_tx_data got n=%0d want n=5 in order", dev_rx.size()); end
  endtask

  task automatic test_soft_reset;
    for (int i = 0; i < 3; i++) wb_w(DATA, 8'($urandom));
    wb_r(TXL, r);
    n_chk++;
    if (r !== 8'd3) begin n_fail++; $display("FAIL srst_pre_txcnt got %0d want 3", r); end
    wb_w(CTRL, 8'h86);
    wb_r(TXL, r);
    n_chk++;
    if (r !== 8'd0) begin n_fail++; $display("FAIL srst_txcnt got %0d want 0", r); end
    wb_r(CTRL, r);
    n_chk++;
    if (r !== 8'h06) begin n_fail++; $display("FAIL srst_ctrl got %h want 06", r); end
  endtask

  task automatic test_async_reset;
    int t = 0;
    for (int i = 0; i < 60; i++) host.push_back(8'($urandom));
    @(negedge clk_i);
    rx_go = 1;
    while (rd_no && t < 50) begin @(negedge clk_i); t++; end
    n_chk++;
    if (rd_no !== 1'b0) begin n_fail++; $display("FAIL arst_rd_start rd_no=%b want 0", rd_no); end
    @(posedge clk_i);
    #3;
    rst_i = 1;
    #1;
    n_chk++;
    if ({rd_no, oe_no, wr_no, pd_oe_o} !== 4'b1110) begin
      n_fail++;
      $display("FAIL arst_strobes got %b want 1110", {rd_no, oe_no, wr_no, pd_oe_o});
    end
    rx_go = 0;
    host.delete();
    idle(2);
    rst_i = 0;
    idle(2);
    wb_r(RXL, r);
    n_chk++;
    if (r !== 8'h00) begin n_fail++; $display("FAIL arst_rxcnt got %h want 00", r); end
    wb_r(CTRL, r);
    n_chk++;
    if (r !== 8'h06) begin n_fail++; $display("FAIL arst_ctrl got %h want 06", r); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_fair();
    test_tx_full();
    test_underflow();
    test_irq();
    test_loopback();
    test_soft_reset();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
